// File: rtl/bram_stream_reader.sv
// Burst reader: streams `length` consecutive words from a BRAM read port onto a
// valid/ready interface through a 2-entry skid buffer.
module bram_stream_reader #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [BRAM_ADDR_WIDTH:0]   length,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] rd_data,
    output logic [BRAM_DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]                 state;
    logic [BRAM_ADDR_WIDTH:0]   remaining;
    logic                       inflight;
    logic [1:0]                 occ;
    logic [BRAM_DATA_WIDTH-1:0] head;
    logic [BRAM_DATA_WIDTH-1:0] tail;
    logic                       done_q;

    logic       pop;
    logic       capture;
    logic [2:0] pending;
    logic       issue;
    logic       last_issue;
    logic       last_pop;

    assign out_valid = (occ != 2'd0);
    assign out_data  = head;
    assign busy      = (state != IDLE);
    assign done      = done_q;

    assign pop     = out_valid & out_ready;
    assign capture = inflight;
    // Words that will occupy the buffer next cycle if nothing new is issued;
    // a read is only launched when its data is guaranteed a free slot.
    assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == RUN) && (remaining != '0) && (pending <= 3'd1);
    assign last_issue = issue && (remaining == (BRAM_ADDR_WIDTH+1)'(1));
    assign last_pop   = (state == DRAIN) && pop && (occ == 2'd1) && !inflight;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            head      <= '0;
            tail      <= '0;
            done_q    <= 1'b0;
            rd_addr   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= RUN;
                            rd_addr   <= base_addr;
                            remaining <= length;
                        end
                    end
                end
                RUN: begin
                    if (last_issue) state <= DRAIN;
                end
                DRAIN: begin
                    if (last_pop) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                rd_addr   <= rd_addr + BRAM_ADDR_WIDTH'(1);
                remaining <= remaining - (BRAM_ADDR_WIDTH+1)'(1);
            end
            inflight <= issue;

            // head is the stream output; tail only holds a word while head is stalled
            if (capture && !pop) begin
                if (occ == 2'd0) head <= rd_data;
                else             tail <= rd_data;
                occ <= occ + 2'd1;
            end else if (!capture && pop) begin
                head <= tail;
                occ  <= occ - 2'd1;
            end else if (capture && pop) begin
                if (occ == 2'd1) begin
                    head <= rd_data;
                end else begin
                    head <= tail;
                    tail <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a BRAM model preloaded with mem[i]=i.
module tb_bram_stream_reader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    bram_stream_reader #(.BRAM_ADDR_WIDTH(10), .BRAM_DATA_WIDTH(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    // Synchronous-read BRAM holding mem[i] = i[7:0]
    always @(posedge clock) rd_data <= rd_addr[7:0];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller drives start/base/length in cycle T; this walks T+1..T+len+4.
    task automatic run_burst(input logic [9:0] b, input int len, input bit poke);
        logic [9:0] a;
        for (int k = 1; k <= len + 4; k++) begin
            step();
            if (k == 1) begin
                start = 1'b0;
                if (poke) begin
                    start     = 1'b1;
                    base_addr = 10'h080;
                    length    = 11'd5;
                end
            end else if (k == 2) begin
                start = 1'b0;
            end
            chk("busy", {31'd0, busy}, {31'd0, (k <= len + 2)});
            chk("done", {31'd0, done}, {31'd0, (k == len + 3)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (k >= 3 && k <= len + 2)});
            if (k <= len) begin
                a = b + 10'(k - 1);
                chk("rd_addr", {22'd0, rd_addr}, {22'd0, a});
            end
            if (k >= 3 && k <= len + 2) begin
                a = b + 10'(k - 3);
                chk("out_data", {24'd0, out_data}, {24'd0, a[7:0]});
            end
        end
    endtask

    initial begin : stim
        int   idx;
        bit   finished;
        bit   prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp8;
        int   maxocc;

        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", {22'd0, rd_addr}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);

        // Basic burst, started in the first cycle after reset release
        reset_n   = 1'b1;
        start     = 1'b1;
        base_addr = 10'h010;
        length    = 11'd4;
        run_burst(10'h010, 4, 1'b0);

        // Address wrap
        start     = 1'b1;
        base_addr = 10'h3FE;
        length    = 11'd4;
        run_burst(10'h3FE, 4, 1'b0);

        // Random backpressure
        start     = 1'b1;
        base_addr = 10'h020;
        length    = 11'd16;
        step();
        start      = 1'b0;
        idx        = 0;
        finished   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        maxocc     = 0;
        for (int c = 0; c < 300 && !finished; c++) begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (int'(dut.occ) > maxocc) maxocc = int'(dut.occ);
            if (done) begin
                finished = 1'b1;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    exp8 = 8'h20 + 8'(idx);
                    chk("rand_data", {24'd0, out_data}, {24'd0, exp8});
                    idx++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                step();
            end
        end
        chk("rand_count", idx, 16);
        chk("rand_done_seen", {31'd0, finished}, 32'd1);
        chk("rand_busy_end", {31'd0, busy}, 32'd0);
        chk("rand_max_occ_le2", {31'd0, (maxocc <= 2)}, 32'd1);
        out_ready = 1'b1;
        step();

        // Zero-length request
        start     = 1'b1;
        base_addr = 10'h100;
        length    = 11'd0;
        step();
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("zero_done_clr", {31'd0, done}, 32'd0);
        chk("zero_busy2", {31'd0, busy}, 32'd0);
        chk("zero_valid2", {31'd0, out_valid}, 32'd0);

        // Start while busy must be ignored
        start     = 1'b1;
        base_addr = 10'h040;
        length    = 11'd3;
        run_burst(10'h040, 3, 1'b1);

        // Reset during third word of an 8-word burst
        start     = 1'b1;
        base_addr = 10'h050;
        length    = 11'd8;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_w1", {24'd0, out_data}, 32'h50);
        step();
        step();
        chk("pre_rst_w3", {24'd0, out_data}, 32'h52);
        reset_n = 1'b0;
        step();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_addr", {22'd0, rd_addr}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        reset_n   = 1'b1;
        start     = 1'b1;
        base_addr = 10'h060;
        length    = 11'd2;
        run_burst(10'h060, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
